// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants and types for the ALU issue/retire controller.
// Opcodes, flag bit positions and the controller state encoding live here.
package alu_issue_ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_LDI   = 4'b0010;
  localparam logic [3:0] OP_SHOWR = 4'b1111;

  localparam int CF = 3;
  localparam int ZF = 2;
  localparam int SF = 1;
  localparam int OF = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WB    = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Small register file: two asynchronous read ports, one synchronous write
// port, cleared asynchronously while reset_n_i is low.
module alu_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int REG_AW = 2
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic [REG_AW-1:0] raddr1_i,
  input  logic [REG_AW-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic              we_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = regs_q[raddr1_i];
  assign rdata2_o = regs_q[raddr2_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/retire controller for the 8-bit ALU: accepts instructions, drives the
// ALU operand/opcode ports for one cycle, writes back the result, samples flags.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 4,
  parameter int REG_AW = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  // Handshake: an instruction is taken on a posedge where instr_valid and
  // instr_ready are both high; the source holds instr stable until then.
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flags_q,
  output logic [DATA_W-1:0] show_data,
  output logic              show_valid,
  output logic              illegal,
  output state_t            dbg_state
);

  state_t            state_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] in1_q, in2_q;
  logic [REG_AW-1:0] rd_q;
  logic [3:0]        flags_r_q;
  logic [DATA_W-1:0] show_data_q;
  logic              show_valid_q;
  logic              illegal_q;

  logic [3:0]        opc;
  logic [REG_AW-1:0] rd_idx, rs_idx;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rdata1, rdata2;
  logic              accept;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  assign opc    = instr[15:12];
  assign rd_idx = instr[11:10];
  assign rs_idx = instr[9:8];
  assign imm    = instr[7:0];
  assign accept = instr_valid && (state_q == S_IDLE);

  // The write port is shared: LDI writes at accept, ADD writes back at ISSUE end.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd_idx;
    rf_wdata = imm;
    if (state_q == S_ISSUE) begin
      rf_we    = (op_q == OP_ADD);
      rf_waddr = rd_q;
      rf_wdata = alu_res;
    end else if (accept && opc == OP_LDI) begin
      rf_we = 1'b1;
    end
  end

  alu_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clock_i   (clock),
    .reset_n_i (reset_n),
    .raddr1_i  (rd_idx),
    .raddr2_i  (rs_idx),
    .rdata1_o  (rdata1),
    .rdata2_o  (rdata2),
    .we_i      (rf_we),
    .waddr_i   (rf_waddr),
    .wdata_i   (rf_wdata)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      op_q         <= OP_NOP;
      in1_q        <= '0;
      in2_q        <= '0;
      rd_q         <= '0;
      flags_r_q    <= '0;
      show_data_q  <= '0;
      show_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      show_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            unique case (opc)
              OP_NOP, OP_LDI: ;
              OP_ADD, OP_SHOWR: begin
                op_q    <= opc;
                in1_q   <= rdata1;
                in2_q   <= rdata2;
                rd_q    <= rd_idx;
                state_q <= S_ISSUE;
              end
              default: illegal_q <= 1'b1;
            endcase
          end
        end
        S_ISSUE: begin
          if (op_q == OP_SHOWR) begin
            show_data_q  <= alu_res;
            show_valid_q <= 1'b1;
          end
          // Return the ALU ports to NOP so repeated ops are distinct events.
          op_q    <= OP_NOP;
          in1_q   <= '0;
          in2_q   <= '0;
          state_q <= S_WB;
        end
        S_WB: begin
          flags_r_q <= alu_flags;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == S_IDLE);
  assign alu_op      = op_q;
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign flags_q     = flags_r_q;
  assign show_data   = show_data_q;
  assign show_valid  = show_valid_q;
  assign illegal     = illegal_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, register model, and queues of
// expected ALU issues and SHOWR outputs checked by a negedge monitor.
module tb_alu_issue_ctrl;
  import alu_issue_ctrl_pkg::*;

  logic        clock;
  logic        reset_n;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  alu_op;
  logic [7:0]  alu_in1, alu_in2, alu_res;
  logic [3:0]  alu_flags;
  logic [3:0]  flags_q;
  logic [7:0]  show_data;
  logic        show_valid;
  logic        illegal;
  state_t      dbg_state;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [19:0] exp_issue_q[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  mdl_regs[4];
  logic        prev_nonnop;

  alu_issue_ctrl dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .alu_op      (alu_op),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_res     (alu_res),
    .alu_flags   (alu_flags),
    .flags_q     (flags_q),
    .show_data   (show_data),
    .show_valid  (show_valid),
    .illegal     (illegal),
    .dbg_state   (dbg_state)
  );

  // ---- clock / reset ----
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---- behavioural ALU: combinational result, flags latched on posedge ----
  always_comb begin
    alu_res = 8'h00;
    if (alu_op == 4'b0001) alu_res = alu_in1 + alu_in2;
    else if (alu_op == 4'b1111) alu_res = alu_in1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) alu_flags <= 4'b0000;
    else if (alu_op == 4'b0001) begin
      logic [8:0] s;
      s = {1'b0, alu_in1} + {1'b0, alu_in2};
      alu_flags <= {s[8], (s[7:0] == 8'h00), s[7],
                    (alu_in1[7] == alu_in2[7]) && (s[7] != alu_in1[7])};
    end
  end

  // ---- monitor / scoreboard ----
  always @(negedge clock) begin
    if (reset_n) begin
      if (alu_op != 4'b0000) begin
        logic [19:0] exp_i;
        chk_cnt++;
        if (exp_issue_q.size() == 0) begin
          $display("FAIL issue_unexpected: got op=%h in1=%h in2=%h, none expected", alu_op, alu_in1, alu_in2);
        end else begin
          exp_i = exp_issue_q.pop_front();
          if ({alu_op, alu_in1, alu_in2} !== exp_i)
            $display("FAIL issue_operands: got %h, expected %h", {alu_op, alu_in1, alu_in2}, exp_i);
          else pass_cnt++;
        end
        chk_cnt++;
        if (prev_nonnop) $display("FAIL issue_nop_gap: alu_op non-NOP in two consecutive cycles");
        else pass_cnt++;
      end
      if (show_valid) begin
        logic [7:0] exp_s;
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL show_unexpected: got show_data=%h, none expected", show_data);
        end else begin
          exp_s = exp_q.pop_front();
          if (show_data !== exp_s) $display("FAIL show_data: got %h, expected %h", show_data, exp_s);
          else pass_cnt++;
        end
      end
    end
    prev_nonnop = reset_n && (alu_op != 4'b0000);
  end

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [3:0] opc, input logic [1:0] rd, input logic [1:0] rs,
                      input logic [7:0] imm);
    int n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    if (!instr_ready) begin
      chk_cnt++;
      $display("FAIL send_timeout: instr_ready=%b, expected 1 within 20 cycles", instr_ready);
    end
    instr       = {opc, rd, rs, imm};
    instr_valid = 1'b1;
    case (opc)
      4'b0010: mdl_regs[rd] = imm;
      4'b0001: begin
        exp_issue_q.push_back({opc, mdl_regs[rd], mdl_regs[rs]});
        mdl_regs[rd] = mdl_regs[rd] + mdl_regs[rs];
      end
      4'b1111: begin
        exp_issue_q.push_back({opc, mdl_regs[rd], mdl_regs[rs]});
        exp_q.push_back(mdl_regs[rd]);
      end
      default: ;
    endcase
    tick();
    instr_valid = 1'b0;
    instr       = 16'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_issue_q.size() != 0 || exp_q.size() != 0 || !instr_ready) && n < 50) begin
      tick();
      n++;
    end
    chk_cnt++;
    if (exp_issue_q.size() != 0 || exp_q.size() != 0 || !instr_ready)
      $display("FAIL drain_timeout: pending issues=%0d shows=%0d ready=%b, expected all empty",
               exp_issue_q.size(), exp_q.size(), instr_ready);
    else pass_cnt++;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    for (int i = 0; i < 4; i++) mdl_regs[i] = 8'h00;
    exp_issue_q.delete();
    exp_q.delete();
    #23;
    reset_n = 1'b1;
    tick();
  endtask

  // ---- tests ----
  task automatic test_reset();
    do_reset();
    chk_cnt++;
    if ({instr_ready, alu_op, alu_in1, alu_in2} !== {1'b1, 4'h0, 8'h00, 8'h00})
      $display("FAIL reset_ports: got ready=%b op=%h in1=%h in2=%h, expected 1/0/00/00",
               instr_ready, alu_op, alu_in1, alu_in2);
    else pass_cnt++;
    chk_cnt++;
    if ({flags_q, show_data, show_valid, illegal} !== 14'h0)
      $display("FAIL reset_outputs: got flags=%b show=%h sv=%b ill=%b, expected zeros",
               flags_q, show_data, show_valid, illegal);
    else pass_cnt++;
    chk_cnt++;
    if (dbg_state !== S_IDLE) $display("FAIL reset_state: got %0d, expected %0d", dbg_state, S_IDLE);
    else pass_cnt++;
  endtask

  task automatic check_add_timing(input string name, input logic [3:0] exp_flags);
    chk_cnt++;
    if (instr_ready !== 1'b0) $display("FAIL %s_ready_c1: got %b, expected 0", name, instr_ready);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (instr_ready !== 1'b0 || alu_op !== 4'b0000)
      $display("FAIL %s_ready_c2: got ready=%b op=%h, expected 0/0", name, instr_ready, alu_op);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (instr_ready !== 1'b1 || flags_q !== exp_flags)
      $display("FAIL %s_flags: got ready=%b flags=%b, expected 1/%b", name, instr_ready, flags_q, exp_flags);
    else pass_cnt++;
  endtask

  task automatic test_add_overflow();
    send(OP_LDI, 2'd0, 2'd0, 8'h7F);
    send(OP_LDI, 2'd1, 2'd0, 8'h01);
    send(OP_ADD, 2'd0, 2'd1, 8'h00);
    check_add_timing("add_ovf", 4'b0011);
    send(OP_SHOWR, 2'd0, 2'd0, 8'h00);
    drain();
  endtask

  task automatic test_add_carry();
    send(OP_LDI, 2'd2, 2'd0, 8'hFF);
    send(OP_LDI, 2'd3, 2'd0, 8'h01);
    send(OP_ADD, 2'd2, 2'd3, 8'h00);
    check_add_timing("add_cy", 4'b1100);
    send(OP_SHOWR, 2'd2, 2'd1, 8'h00);
    drain();
    chk_cnt++;
    if (flags_q !== 4'b1100) $display("FAIL showr_keeps_flags: got %b, expected 1100", flags_q);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    send(OP_LDI, 2'd0, 2'd0, 8'h01);
    send(OP_LDI, 2'd1, 2'd0, 8'h01);
    send(OP_ADD, 2'd0, 2'd1, 8'h00);
    send(OP_ADD, 2'd0, 2'd1, 8'h00);
    send(OP_ADD, 2'd1, 2'd1, 8'h00);
    drain();
    chk_cnt++;
    if (flags_q !== 4'b0000) $display("FAIL b2b_flags: got %b, expected 0000", flags_q);
    else pass_cnt++;
    send(OP_SHOWR, 2'd0, 2'd0, 8'h00);
    send(OP_SHOWR, 2'd1, 2'd0, 8'h00);
    drain();
  endtask

  task automatic test_showr();
    send(OP_LDI, 2'd1, 2'd0, 8'hA5);
    send(OP_SHOWR, 2'd1, 2'd0, 8'h00);
    chk_cnt++;
    if (show_valid !== 1'b0) $display("FAIL showr_early: got show_valid=%b, expected 0", show_valid);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (show_valid !== 1'b1 || show_data !== 8'hA5)
      $display("FAIL showr_pulse: got sv=%b data=%h, expected 1/a5", show_valid, show_data);
    else pass_cnt++;
    tick();
    chk_cnt++;
    if (show_valid !== 1'b0 || flags_q !== 4'b0000 || show_data !== 8'hA5)
      $display("FAIL showr_after: got sv=%b flags=%b data=%h, expected 0/0000/a5",
               show_valid, flags_q, show_data);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_illegal();
    send(4'b0101, 2'd1, 2'd2, 8'h33);
    chk_cnt++;
    if (illegal !== 1'b1 || instr_ready !== 1'b1 || alu_op !== 4'b0000 || flags_q !== 4'b0000)
      $display("FAIL illegal_set: got ill=%b ready=%b op=%h flags=%b, expected 1/1/0/0000",
               illegal, instr_ready, alu_op, flags_q);
    else pass_cnt++;
    send(OP_NOP, 2'd1, 2'd1, 8'hFF);
    send(OP_LDI, 2'd3, 2'd0, 8'h5C);
    chk_cnt++;
    if (illegal !== 1'b1 || alu_op !== 4'b0000)
      $display("FAIL illegal_sticky: got ill=%b op=%h, expected 1/0", illegal, alu_op);
    else pass_cnt++;
    send(OP_SHOWR, 2'd1, 2'd0, 8'h00);
    send(OP_SHOWR, 2'd3, 2'd0, 8'h00);
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [3:0] opc;
      case ($urandom_range(0, 3))
        0: opc = OP_LDI;
        1: opc = OP_ADD;
        2: opc = OP_SHOWR;
        default: opc = OP_NOP;
      endcase
      send(opc, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    send(OP_LDI, 2'd0, 2'd0, 8'h10);
    send(OP_LDI, 2'd1, 2'd0, 8'h20);
    send(OP_ADD, 2'd0, 2'd1, 8'h00);
    chk_cnt++;
    if (dbg_state !== S_ISSUE) $display("FAIL rstmid_in_issue: got %0d, expected %0d", dbg_state, S_ISSUE);
    else pass_cnt++;
    #1;
    reset_n = 1'b0;
    #1;
    chk_cnt++;
    if (alu_op !== 4'b0000 || flags_q !== 4'b0000 || dbg_state !== S_IDLE || show_data !== 8'h00)
      $display("FAIL rstmid_immediate: got op=%h flags=%b state=%0d show=%h, expected 0/0000/0/00",
               alu_op, flags_q, dbg_state, show_data);
    else pass_cnt++;
    exp_issue_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) mdl_regs[i] = 8'h00;
    #14;
    reset_n = 1'b1;
    tick();
    tick();
    send(OP_SHOWR, 2'd0, 2'd1, 8'h00);
    send(OP_SHOWR, 2'd1, 2'd0, 8'h00);
    drain();
  endtask

  initial begin
    prev_nonnop = 1'b0;
    test_reset();
    test_add_overflow();
    test_add_carry();
    test_back_to_back();
    test_showr();
    test_illegal();
    test_random();
    test_reset_mid();
    repeat (3) tick();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue/retire controller that drives the 8-bit ALU's operand/opcode interface and consumes its result and flag outputs. It accepts 16-bit instructions over a valid/ready handshake and reads operands from a local 4x8 register file. It then drives alu_op/alu_in1/alu_in2 for exactly one cycle, writes alu_res back, and samples the registered flags one cycle later. It sits between the instruction source (switch/ROM front end) and the ALU.

Parameters:
DATA_W, 8, operand/result width (must match ALU)
NREGS, 4, register file depth
REG_AW, 2, register index width (log2 NREGS)

Ports:
clock  in  1  system clock; ALU evaluates in low phase, latches flags on posedge
reset_n  in  1  asynchronous active-low reset
instr  in  16  {opcode[15:12], rd[11:10], rs[9:8], imm[7:0]}
instr_valid  in  1  instr is presented
instr_ready  out  1  controller can accept; high only in IDLE
alu_op  out  4  opcode to ALU (0000 NOP, 0001 ADD, 1111 SHOWR)
alu_in1  out  8  operand 1 to ALU (reg[rd])
alu_in2  out  8  operand 2 to ALU (reg[rs])
alu_res  in  8  ALU result
alu_flags  in  4  ALU {CF,ZF,SF,OF}, registered inside ALU
flags_q  out  4  architectural {CF,ZF,SF,OF}
show_data  out  8  SHOWR output value
show_valid  out  1  one-cycle pulse when show_data updates
illegal  out  1  sticky; set on an unsupported opcode

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all regs=0; alu_op=0000; alu_in1=alu_in2=0; flags_q=0; show_data=0; show_valid=0; illegal=0. Reset mid-ISSUE/WB abandons the instruction with no writeback.
- FSM: IDLE -> ISSUE -> WB -> IDLE. instr_ready = (state==IDLE). Accept on a posedge with instr_valid && instr_ready.
- Accepted opcode, by value:
  - 0000 NOP: no state change; stays IDLE.
  - 0010 LDI: reg[rd] <= imm at the accept edge; stays IDLE; flags untouched.
  - 0001 ADD, 1111 SHOWR: register alu_op=opcode, alu_in1=reg[rd], alu_in2=reg[rs] at the accept edge; go to ISSUE.
  - Any other opcode: illegal <= 1; stays IDLE; no other effect.
- ISSUE (1 cycle): alu_* held. On the ending posedge:
  - ADD: reg[rd] <= alu_res.
  - SHOWR: show_data <= alu_res and show_valid pulses for one cycle (the WB cycle).
  - In both cases alu_op/in1/in2 <= 0 (NOP). Go to WB.
- WB (1 cycle): on the ending posedge, flags_q <= alu_flags, which the ALU has latched at the ISSUE-end edge. Go to IDLE.
- ALU result latency: 1 cycle; flag latency: 2 cycles after the accept edge. Throughput: one ALU instruction per 3 cycles; LDI/NOP one per cycle.
- alu_op is NOP in every cycle except ISSUE. Consecutive identical ADDs therefore always present a new input event to the ALU.
- ADD with rd==rs is legal: in1=in2=reg[rd].
- SHOWR leaves flags unchanged; flags_q re-samples the same value.
- instr_valid deasserted: controller idles; alu_op stays NOP.
- instr is not sampled outside IDLE. The source must hold instr stable until accepted.

Decomposition:
- Shared package: opcode constants OP_NOP=4'b0000, OP_ADD=4'b0001, OP_LDI=4'b0010, OP_SHOWR=4'b1111.
- Shared package: flag bit indices CF=3, ZF=2, SF=1, OF=0.
- Shared package: FSM state encoding IDLE/ISSUE/WB.
- One sub-module: alu_regfile. It holds NREGS x DATA_W, with two async read ports, one sync write port and async clear on reset_n.
- The FSM and ALU-port registers stay in the top.

Test Plan:
- LDI r0,0x7F; LDI r1,0x01; ADD r0,r1 -> alu_op=0001, in1=0x7F, in2=0x01 for exactly 1 cycle; r0=0x80; flags_q=4'b0011 (SF,OF) two cycles after accept.
- LDI r2,0xFF; LDI r3,0x01; ADD r2,r3 -> r2=0x00; flags_q=4'b1100 (CF,ZF); instr_ready low for 2 cycles after accept.
- Back-to-back ADD r0,r1 twice (r0=1,r1=1) -> alu_op shows NOP between the two issues; r0 ends at 0x03; flags_q=0000.
- LDI r1,0xA5; SHOWR r1 -> show_data=0xA5 with a 1-cycle show_valid pulse; flags_q unchanged from prior value.
- Opcode 4'b0101 -> illegal=1 (sticky); regs, flags_q and alu_op unchanged; instr_ready stays high.
- Assert reset_n=0 during ISSUE of ADD -> immediately all regs=0, alu_op=0000, flags_q=0, state IDLE; no writeback after release.
